// File: rtl/puf_resp_framer.sv
// Frames a captured PUF response (header, challenge echo, response bytes) onto a byte valid/ready stream.
// Optional trailing XOR checksum byte when RESP_FRAMER_CHKSUM_EN is defined.
module puf_resp_framer #(
  parameter int unsigned RESP_W    = 128,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resp_valid,
  input  logic [15:0]       challenge,
  input  logic [RESP_W-1:0] response,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned NB    = RESP_W / 8;
`ifdef RESP_FRAMER_CHKSUM_EN
  localparam int unsigned FLEN  = 4 + NB;
`else
  localparam int unsigned FLEN  = 3 + NB;
`endif
  localparam int unsigned CNT_W = $clog2(FLEN);
  localparam int unsigned SH_W  = RESP_W + 16;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic              rv_q;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
`ifdef RESP_FRAMER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              rise, hs, last, load;
  logic [RESP_W-1:0] resp_ord;

  // Reorder response so the first byte to send is always the top byte of the shifter
  generate
    if (MSB_FIRST) begin : g_msb
      assign resp_ord = response;
    end else begin : g_lsb
      for (genvar i = 0; i < NB; i++) begin : g_rev
        assign resp_ord[8*i +: 8] = response[RESP_W-8-8*i +: 8];
      end
    end
  endgenerate

  assign rise = resp_valid & ~rv_q;
  assign hs   = tx_valid_q & tx_ready;
  assign last = (cnt_q == CNT_W'(FLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rv_q         <= 1'b0;
      sh_q         <= '0;
      cnt_q        <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RESP_FRAMER_CHKSUM_EN
      chk_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      rv_q         <= resp_valid;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef RESP_FRAMER_CHKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
`ifdef RESP_FRAMER_CHKSUM_EN
    chk_d        = chk_q;
`endif
    load         = 1'b0;

    case (state_q)
      IDLE: load = rise;
      SEND: begin
        if (hs && last) begin
          frame_done_d = 1'b1;
          // A rise coinciding with the final handshake chains straight into a new frame
          load         = rise;
          if (!rise) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
          end
        end else begin
          if (rise) overrun_d = 1'b1;
          if (hs) begin
            cnt_d     = cnt_q + CNT_W'(1);
            tx_data_d = sh_q[SH_W-1 -: 8];
            sh_d      = sh_q << 8;
`ifdef RESP_FRAMER_CHKSUM_EN
            if (cnt_q != '0) chk_d = chk_q ^ tx_data_q;
            if (cnt_q == CNT_W'(FLEN - 2)) tx_data_d = chk_q ^ tx_data_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d    = SEND;
      sh_d       = {challenge, resp_ord};
      cnt_d      = '0;
      tx_data_d  = HDR_BYTE;
      tx_valid_d = 1'b1;
      busy_d     = 1'b1;
      overrun_d  = 1'b0;
`ifdef RESP_FRAMER_CHKSUM_EN
      chk_d      = 8'h00;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
